// File: rtl/sync_fifo_ctr.sv
// Single-clock FIFO with occupancy count, programmable flags and error strobes.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_ctr #(
    parameter int WIDTH             = 64,
    parameter int DEPTH             = 64,
    parameter int PROG_FULL_THRESH  = DEPTH - 8,
    parameter int PROG_EMPTY_THRESH = 4,
    localparam int AW               = $clog2(DEPTH),
    localparam int CW               = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             empty,
    output logic             full,
    output logic             prog_full,
    output logic             prog_empty,
    output logic [CW-1:0]    data_count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_PF    = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] LP_PE    = CW'(PROG_EMPTY_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_ovf;
    logic             r_udf;

    logic             w_rd;
    logic             w_wr;
    logic             w_mem_we;

`ifdef SYNC_FIFO_FWFT_EN
    logic             w_load;
    logic             w_mem_empty;
    logic             w_bypass;

    // r_count covers the presented word; the array holds the rest
    assign w_mem_empty = (r_count == {{(CW-1){1'b0}}, r_valid});
    assign w_rd        = rd_en & r_valid;
    assign w_load      = ~r_valid | w_rd;
    assign w_bypass    = w_load & w_mem_empty;
    assign w_wr        = wr_en & (~full | w_rd);
    assign w_mem_we    = w_wr & ~w_bypass;
    assign empty       = ~r_valid;
`else
    assign w_rd        = rd_en & ~empty;
    assign w_wr        = wr_en & (~full | w_rd);
    assign w_mem_we    = w_wr;
    assign empty       = (r_count == '0);
`endif

    assign full       = (r_count == LP_DEPTH);
    assign prog_full  = (r_count >= LP_PF);
    assign prog_empty = (r_count <= LP_PE);
    assign data_count = r_count;
    assign dout       = r_dout;
    assign valid      = r_valid;
    assign overflow   = r_ovf;
    assign underflow  = r_udf;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_ovf <= wr_en & ~w_wr;
            r_udf <= rd_en & ~w_rd;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
        end else if (w_load) begin
            if (!w_mem_empty) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_valid  <= 1'b1;
            end else if (w_wr) begin
                r_dout  <= din;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_rd) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_valid <= w_rd;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctr.sv
// Bench for sync_fifo_ctr: queue model checked every cycle plus directed
// literal expectations. Honours SYNC_FIFO_FWFT_EN like the design.
module tb_sync_fifo_ctr;

    localparam int W   = 16;
    localparam int D   = 8;
    localparam int PFT = 6;
    localparam int PET = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  dout;
    logic          valid;
    logic          empty;
    logic          full;
    logic          prog_full;
    logic          prog_empty;
    logic [3:0]    data_count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_bad = 0;

    sync_fifo_ctr #(
        .WIDTH(W),
        .DEPTH(D),
        .PROG_FULL_THRESH(PFT),
        .PROG_EMPTY_THRESH(PET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .dout(dout),
        .valid(valid),
        .empty(empty),
        .full(full),
        .prog_full(prog_full),
        .prog_empty(prog_empty),
        .data_count(data_count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: contents as a queue, outputs from the rules
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;
    logic         m_init = 1'b0;

    always @(posedge clk) begin
        automatic bit rd_ok;
        automatic bit wr_ok;
        if (rst) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            rd_ok = rd_en && (q.size() > 0);
            wr_ok = wr_en && (q.size() < D || rd_ok);
`ifdef SYNC_FIFO_FWFT_EN
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(din);
            if (q.size() > 0) m_dout = q[0];
            m_valid = (q.size() > 0);
`else
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(din);
            m_valid = rd_ok;
`endif
            m_ovf = wr_en && !wr_ok;
            m_udf = rd_en && !rd_ok;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("m_count", data_count, q.size());
            chk("m_empty", empty, q.size() == 0);
            chk("m_full", full, q.size() == D);
            chk("m_pfull", prog_full, q.size() >= PFT);
            chk("m_pempty", prog_empty, q.size() <= PET);
            chk("m_valid", valid, m_valid);
            chk("m_ovf", overflow, m_ovf);
            chk("m_udf", underflow, m_udf);
`ifdef SYNC_FIFO_FWFT_EN
            if (m_valid) chk("m_dout", dout, m_dout);
`else
            chk("m_dout", dout, m_dout);
`endif
        end
    end

    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_empty", empty, 1);
        chk("rst_pempty", prog_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pfull", prog_full, 0);
        chk("rst_count", data_count, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
    endtask

    initial begin
        @(negedge clk);
        #1;
        rst = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0);
        chk_reset_state();

        for (int i = 1; i <= D; i++) begin
            step(1, 0, W'(i));
            chk("fill_count", data_count, i);
            chk("fill_pempty", prog_empty, i <= 2);
            chk("fill_pfull", prog_full, i >= 6);
        end
        chk("fill_full", full, 1);

        step(1, 0, 16'h0009);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", data_count, 8);
        step(0, 0, 0);
        chk("ovf_clear", overflow, 0);

        for (int i = 1; i <= D; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("drain_head", dout, i);
            chk("drain_hvld", valid, 1);
            step(0, 1, 0);
`else
            step(0, 1, 0);
            chk("drain_dout", dout, i);
            chk("drain_valid", valid, 1);
`endif
            chk("drain_count", data_count, 8 - i);
            chk("drain_pempty", prog_empty, (8 - i) <= 2);
            chk("drain_pfull", prog_full, (8 - i) >= 6);
        end
        step(0, 0, 0);
        chk("drained_empty", empty, 1);
        chk("drained_valid", valid, 0);

        for (int i = 1; i <= D; i++) step(1, 0, W'(i));
        for (int k = 0; k < 20; k++) begin
            automatic int exp_v = (k < 8) ? k + 1 : 100 + k - 8;
`ifdef SYNC_FIFO_FWFT_EN
            chk("wrap_head", dout, exp_v);
            step(1, 1, W'(100 + k));
`else
            step(1, 1, W'(100 + k));
            chk("wrap_dout", dout, exp_v);
`endif
            chk("wrap_ovf", overflow, 0);
            chk("wrap_count", data_count, 8);
        end
        for (int i = 0; i < D; i++) step(0, 1, 0);
        step(0, 0, 0);
        chk("wrap_empty", empty, 1);

        step(1, 1, 16'hAAAA);
        chk("udf_pulse", underflow, 1);
        chk("udf_count", data_count, 1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("udf_fvalid", valid, 1);
        chk("udf_fdout", dout, 16'hAAAA);
        step(0, 1, 0);
        chk("udf_pop_valid", valid, 0);
        chk("udf_pop_empty", empty, 1);
`else
        chk("udf_valid", valid, 0);
        step(0, 1, 0);
        chk("udf_rd_dout", dout, 16'hAAAA);
        chk("udf_rd_valid", valid, 1);
        chk("udf_rd_count", data_count, 0);
`endif
        step(0, 0, 0);

`ifdef SYNC_FIFO_FWFT_EN
        step(1, 0, 16'h1234);
        chk("fwft_dout", dout, 16'h1234);
        chk("fwft_valid", valid, 1);
        chk("fwft_nempty", empty, 0);
        step(0, 0, 0);
        chk("fwft_hold", dout, 16'h1234);
        step(0, 1, 0);
        chk("fwft_ack_valid", valid, 0);
        chk("fwft_ack_empty", empty, 1);
`endif

        for (int i = 0; i < 4; i++) step(1, 0, W'(16'h50 + i));
        chk("half_count", data_count, 4);
        rst = 1'b1;
        step(1, 1, 16'hFFFF);
        rst = 1'b0;
        chk_reset_state();
        step(0, 0, 0);
        chk("post_rst_count", data_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
